// File: rtl/conv_stage2_accumulate_if.sv
// Partial-product input and filtered-pixel output streams of the convolution accumulate stage.
// master drives the partial products and out_ready; slave is the accumulator itself.
interface conv_stage2_accumulate_if #(
  parameter int unsigned OUT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [4:0]       p1;
  logic signed [4:0]       p2;
  logic        [5:0]       p3;
  logic signed [4:0]       p4;
  logic signed [4:0]       p5;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  modport master (
    output in_valid, p1, p2, p3, p4, p5, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, p1, p2, p3, p4, p5, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_stage2_accumulate.sv
// Two-stage pipelined adder tree summing five 3x3-conv partial products, with frame tagging.
// Optional build macro CONV_RELU_EN clamps negative window sums to zero.
module conv_stage2_accumulate #(
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_stage2_accumulate_if.slave bus,
  output logic [CNT_W-1:0]       result_cnt
);

  localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  logic                    va_q, va_d;
  logic signed [7:0]       a0_q, a0_d;
  logic signed [7:0]       a1_q, a1_d;
  logic signed [7:0]       a2_q, a2_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    adv_a, adv_b, accept, handshake;
  logic signed [7:0]       sum_raw, sum_sel;

  always_comb begin
    adv_b     = !out_valid_q || bus.out_ready;
    adv_a     = !va_q || adv_b;
    accept    = bus.in_valid && adv_a;
    handshake = out_valid_q && bus.out_ready;

    // |sum| <= 60, so 8-bit wrap-free arithmetic is exact
    sum_raw = a0_q + a1_q + a2_q;
`ifdef CONV_RELU_EN
    sum_sel = sum_raw[7] ? 8'sd0 : sum_raw;
`else
    sum_sel = sum_raw;
`endif

    va_d        = va_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    if (adv_a) begin
      va_d = bus.in_valid;
    end
    // p3 is the x4 centre term and is never negative: zero-extend it
    if (accept) begin
      a0_d = {{3{bus.p1[4]}}, bus.p1} + {{3{bus.p2[4]}}, bus.p2};
      a1_d = {{3{bus.p4[4]}}, bus.p4} + {{3{bus.p5[4]}}, bus.p5};
      a2_d = {2'b00, bus.p3};
    end

    if (adv_b) begin
      out_valid_d = va_q;
      if (va_q) begin
        out_data_d = OUT_W'(sum_sel);
      end
    end

    if (handshake) begin
      cnt_d = cnt_q + 1'b1;
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q        <= 1'b0;
      a0_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      va_q        <= va_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = adv_a;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_valid_q && (idx_q == LastIdx);
  assign result_cnt    = cnt_q;

endmodule

// File: tb/tb_conv_stage2_accumulate.sv
// Self-checking bench for conv_stage2_accumulate: directed vector table, stall, frame,
// reset and random-handshake sequences against a queue scoreboard.
module tb_conv_stage2_accumulate;

  localparam int unsigned OutW     = 8;
  localparam int unsigned FrameLen = 16;
  localparam int unsigned CntW     = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CntW-1:0] result_cnt;

  conv_stage2_accumulate_if #(.OUT_W(OutW)) bus ();

  conv_stage2_accumulate #(
    .OUT_W    (OutW),
    .FRAME_LEN(FrameLen),
    .CNT_W    (CntW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [4:0] p1;
    logic signed [4:0] p2;
    logic signed [4:0] p4;
    logic signed [4:0] p5;
    logic        [5:0] p3;
    int                raw_sum;
  } vec_t;

  vec_t vecs[7];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int m_idx    = 0;
  int m_cnt    = 0;
  int last_seen    = 0;
  int last_pos_sum = 0;

  function automatic int relu(int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int ref_sum(logic signed [4:0] a, logic signed [4:0] b,
                                 logic signed [4:0] c, logic signed [4:0] d, logic [5:0] e);
    int ia = a;
    int ib = b;
    int ic = c;
    int id = d;
    int ie = e;
    return relu(ia + ib + ic + id + ie);
  endfunction

  task automatic check(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(int i, int a, int b, int c, int d, int e, int s);
    vecs[i].p1 = 5'(a);
    vecs[i].p2 = 5'(b);
    vecs[i].p4 = 5'(c);
    vecs[i].p5 = 5'(d);
    vecs[i].p3 = 6'(e);
    vecs[i].raw_sum = s;
  endtask

  task automatic drive_set(logic signed [4:0] a, logic signed [4:0] b,
                           logic signed [4:0] c, logic signed [4:0] d, logic [5:0] e);
    bus.p1 = a;
    bus.p2 = b;
    bus.p4 = c;
    bus.p5 = d;
    bus.p3 = e;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard: pushes reference sums on input accept, pops on output handshake.
  initial begin
    int  e;
    logic prev_stall = 1'b0;
    int  prev_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_idx = 0;
        m_cnt = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", int'(bus.out_valid), 1);
          check("stall_hold_data", int'($signed(bus.out_data)), prev_data);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'($signed(bus.out_data)), e);
          end
          check("out_last", int'(bus.out_last), int'(m_idx == FrameLen - 1));
          if (bus.out_last) begin
            last_seen++;
            last_pos_sum += m_cnt + 1;
          end
          m_idx = (m_idx == FrameLen - 1) ? 0 : m_idx + 1;
          m_cnt++;
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(ref_sum(bus.p1, bus.p2, bus.p4, bus.p5, bus.p3));
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = int'($signed(bus.out_data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    int base_cnt;
    int base_last;
    int base_pos;
    logic saw_block;

    set_vec(0,  -1,  -1,  -1,  -1, 20,  16);
    set_vec(1, -15, -15, -15, -15,  0, -60);
    set_vec(2,   0,   0,   0,   0, 60,  60);
    set_vec(3, -15,   0,   0,   0, 60,  45);
    set_vec(4,  -3,  -5,  -7,  -2, 17,   0);
    set_vec(5,  -8,  -8,  -8,  -8, 33,   1);
    set_vec(6,   0,   0,   0, -15,  0, -15);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_set(5'sd0, 5'sd0, 5'sd0, 5'sd0, 6'd0);
    tick();
    tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'($signed(bus.out_data)), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_result_cnt", int'(result_cnt), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    tick();

    // Single sets: 2-cycle latency, one-cycle valid pulse
    for (int i = 0; i < 7; i++) begin
      drive_set(vecs[i].p1, vecs[i].p2, vecs[i].p4, vecs[i].p5, vecs[i].p3);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      check("vec_in_ready", int'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      check("vec_lat1_valid", int'(bus.out_valid), 0);
      tick();
      check("vec_lat2_valid", int'(bus.out_valid), 1);
      check("vec_data", int'($signed(bus.out_data)), relu(vecs[i].raw_sum));
      tick();
      check("vec_pulse_end", int'(bus.out_valid), 0);
    end
    check("vec_result_cnt", int'(result_cnt), 7);

    // Stall: 8 sets streamed, downstream blocked for cycles 3..7
    base_cnt  = int'(result_cnt);
    sent      = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      bus.out_ready = !(c >= 3 && c < 8);
      bus.in_valid  = 1'b1;
      drive_set(5'(-sent), 5'(-1), 5'(-2), 5'(0), 6'(sent * 7));
      #1;
      if (!bus.in_ready) saw_block = 1'b1;
      else sent++;
      tick();
    end
    drain();
    check("stall_in_ready_fell", int'(saw_block), 1);
    check("stall_sent", sent, 8);
    check("stall_results", int'(result_cnt) - base_cnt, 8);

    // Frame tagging over 33 results
    do_reset();
    base_last = last_seen;
    base_pos  = last_pos_sum;
    sent = 0;
    for (int c = 0; c < 200 && sent < 33; c++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      drive_set(5'(-(c % 16)), 5'sd0, 5'(-1), 5'sd0, 6'((c * 3) % 61));
      #1;
      if (bus.in_ready) sent++;
      tick();
    end
    drain();
    check("frame_result_cnt", int'(result_cnt), 33);
    check("frame_last_count", last_seen - base_last, 2);
    check("frame_last_positions", last_pos_sum - base_pos, 48);

    // Reset with two sets in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_set(-5'sd4, -5'sd4, -5'sd4, -5'sd4, 6'd50);
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("flight_out_valid", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    check("async_rst_out_data", int'($signed(bus.out_data)), 0);
    check("async_rst_out_last", int'(bus.out_last), 0);
    check("async_rst_result_cnt", int'(result_cnt), 0);
    check("async_rst_in_ready", int'(bus.in_ready), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_set(-5'sd2, -5'sd3, 5'sd0, -5'sd1, 6'd12);
    tick();
    drain();
    check("post_rst_result_cnt", int'(result_cnt), 1);

    // Random valid/ready toggling, 1000 sets
    base_cnt = int'(result_cnt);
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      drive_set(5'(-int'($urandom_range(0, 15))), 5'(-int'($urandom_range(0, 15))),
                5'(-int'($urandom_range(0, 15))), 5'(-int'($urandom_range(0, 15))),
                6'($urandom_range(0, 60)));
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      cyc++;
    end
    drain();
    check("rand_sent", sent, 1000);
    check("rand_results", int'(result_cnt) - base_cnt, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
